// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// Routes each ROM-download byte to the SDRAM port or BG loader that owns its
// address, stalls the HPS until the SDRAM handshake completes, and generates
// the game reset (held while the image is absent or loading, plus a trailing
// one-cycle pulse once the hold counter reaches 1).
//
// state | meaning
// IDLE  | waiting for a byte strobe
// ISSUE | request toggled or dl_wr pulsed for the captured byte
// WAIT  | waiting for the selected port's ack to match its req
module rom_load_sequencer #(
  parameter logic [24:0] SP_BASE  = 25'h12000,
  parameter logic [24:0] BG_BASE  = 25'h32000,
  parameter logic [24:0] END_ADDR = 25'h3A000,
  parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic [24:0] dl_addr,
  output logic        dl_wr,
  output logic [7:0]  dl_data,
  output logic        rom_download,
  output logic        rom_loaded,
  output logic        sys_reset
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {R_P1, R_P2, R_BG, R_DROP} region_t;

  function automatic region_t decode(input logic [24:0] a);
    if (a < SP_BASE)       return R_P1;
    else if (a < BG_BASE)  return R_P2;
    else if (a < END_ADDR) return R_BG;
    else                   return R_DROP;
  endfunction

  state_t        state_q, state_d;
  logic          wr_q, dl_q;
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          req1_q, req1_d, req2_q, req2_d;
  logic          dl_wr_q, dl_wr_d;
  logic          wait_q, wait_d;
  logic          loaded_q, loaded_d, pend_q, pend_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          sys_rst_q, sys_rst_d;

  logic          wr_cond, accept, ack_match, dl_rise, dl_fall, rst_cause;
  region_t       in_region, cur_region;
  logic [18:0]   sp_off;

  assign wr_cond      = ioctl_wr && (ioctl_index == 8'd0);
  assign rom_download = ioctl_download && (ioctl_index == 8'd0);
  assign in_region    = decode(ioctl_addr);
  assign cur_region   = decode(addr_q);
  // Out-of-image bytes are never accepted so they leave no trace at all.
  assign accept       = !RESET && (state_q == S_IDLE) && wr_cond && !wr_q &&
                        (in_region != R_DROP);
  assign ack_match    = (cur_region == R_P1) ? (port1_ack == req1_q)
                                             : (port2_ack == req2_q);
  assign dl_rise      = rom_download && !dl_q;
  assign dl_fall      = !rom_download && dl_q;
  assign rst_cause    = RESET || user_reset || !loaded_q;

  // Only the low 19 bits of the sprite offset feed the port2 mapping.
  assign sp_off       = addr_q[18:0] - SP_BASE[18:0];

  assign ioctl_wait = wait_q || accept;
  assign port1_req  = req1_q;
  assign port1_a    = addr_q[23:1];
  assign port1_ds   = {addr_q[0], ~addr_q[0]};
  assign port1_d    = {data_q, data_q};
  assign port1_we   = rom_download;
  assign port2_req  = req2_q;
  assign port2_a    = {5'd0, sp_off[18:17], sp_off[14:0], sp_off[16]};
  assign port2_ds   = {sp_off[15], ~sp_off[15]};
  assign port2_d    = {data_q, data_q};
  assign port2_we   = rom_download;
  assign dl_addr    = addr_q - BG_BASE;
  assign dl_wr      = dl_wr_q;
  assign dl_data    = data_q;
  assign rom_loaded = loaded_q;
  assign sys_reset  = sys_rst_q;

  // Next-state: byte FSM, load-complete tracking and reset hold counter.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    req1_d   = req1_q;
    req2_d   = req2_q;
    dl_wr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          addr_d  = ioctl_addr;
          data_d  = ioctl_dout;
          // Registered so the toggle/pulse is visible during ISSUE.
          case (in_region)
            R_P1:    req1_d  = ~req1_q;
            R_P2:    req2_d  = ~req2_q;
            R_BG:    dl_wr_d = 1'b1;
            default: ;
          endcase
        end
      end
      S_ISSUE: state_d = (cur_region == R_BG) ? S_IDLE : S_WAIT;
      S_WAIT:  if (ack_match) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    wait_d = (state_d != S_IDLE);

    // A falling download edge is remembered until the last byte has landed.
    loaded_d = loaded_q;
    pend_d   = pend_q || dl_fall;
    if (pend_d && (state_q == S_IDLE)) begin
      loaded_d = 1'b1;
      pend_d   = 1'b0;
    end
    if (dl_rise) begin
      loaded_d = 1'b0;
      pend_d   = 1'b0;
    end

    if (rst_cause)           cnt_d = RST_HOLD;
    else if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
    else                     cnt_d = cnt_q;
    sys_rst_d = rst_cause || (cnt_q == 16'd1);
  end

  // State register; reset re-aligns req to ack so no stale handshake survives.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      dl_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      req1_q    <= port1_ack;
      req2_q    <= port2_ack;
      dl_wr_q   <= 1'b0;
      wait_q    <= 1'b0;
      loaded_q  <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= RST_HOLD;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_cond;
      dl_q      <= rom_download;
      addr_q    <= addr_d;
      data_q    <= data_d;
      req1_q    <= req1_d;
      req2_q    <= req2_d;
      dl_wr_q   <= dl_wr_d;
      wait_q    <= wait_d;
      loaded_q  <= loaded_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
    end
  end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences the MiSTer ROM download stream into the shared SDRAM and the background-tile RAM.
- Decodes each ioctl byte by address region and issues exactly one toggle-handshake write per byte to the owning SDRAM port, or one pulse to the BG loader.
- Back-pressures the HPS with ioctl_wait until the SDRAM acknowledges.
- Owns the game reset: held while ROMs are absent or loading, plus the trailing second reset pulse.

## Interface
Parameters:
- SP_BASE, 'h12000, first byte address of the sprite ROM region (served by port2).
- BG_BASE, 'h32000, first byte address of the BG ROM region (served by dl_*).
- END_ADDR, 'h3A000, first address past the image; bytes at or above it are dropped.
- RST_HOLD, 16'hFFFF, reload value of the post-reset counter.

Ports:
- clk_sys  in  1  system clock (40 MHz).
- RESET  in  1  synchronous, active-high.
- user_reset  in  1  OSD reset or user button, level.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  byte strobe.
- ioctl_index  in  8  download index; only 0 is ROM.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to HPS.
- port1_req  out  1  toggle request, main/sound ROM.
- port1_ack  in  1  toggle acknowledge from sdram.
- port1_a  out  23  word address, = ioctl_addr[23:1] of the captured byte.
- port1_ds  out  2  byte select, {a[0], ~a[0]}.
- port1_d  out  16  {byte, byte}.
- port1_we  out  1  write enable.
- port2_req  out  1  toggle request, sprite ROM.
- port2_ack  in  1  toggle acknowledge from sdram.
- port2_a  out  23  {s[18:17], s[14:0], s[16]}, where s = addr − SP_BASE.
- port2_ds  out  2  {s[15], ~s[15]}.
- port2_d  out  16  {byte, byte}.
- port2_we  out  1  write enable.
- dl_addr  out  25  addr − BG_BASE.
- dl_wr  out  1  one-cycle BG write strobe.
- dl_data  out  8  byte data.
- rom_download  out  1  ioctl_download && ioctl_index==0.
- rom_loaded  out  1  a complete ROM image is in memory.
- sys_reset  out  1  reset to the game core.

## Operation
- **Capture:** a byte is accepted on the rising edge of (ioctl_wr && ioctl_index==0), only in IDLE. addr and data are latched into holding registers. All port/dl outputs are driven from these registers.
- **Region decode** on the latched address:
  - addr < SP_BASE: P1.
  - SP_BASE ≤ addr < BG_BASE: P2.
  - BG_BASE ≤ addr < END_ADDR: BG.
  - Otherwise: DROP; no side effect; the state machine stays in IDLE.
- **FSM:**
  - IDLE: on a capture, go to ISSUE.
  - ISSUE: for P1/P2, toggle the selected portN_req and go to WAIT. For BG, pulse dl_wr and return to IDLE.
  - WAIT: exit to IDLE when portN_ack == portN_req.
- **ioctl_wait:** high from the capture cycle through the cycle ack matches. It is never high for BG or DROP bytes beyond the ISSUE cycle.
- **Write enables:** port1_we = port2_we = rom_download. Only the port matching the region toggles; the other port's req is untouched.
- **rom_loaded:**
  - Set on the cycle the FSM is IDLE after a falling edge of rom_download. If WAIT is active at that edge, it is set when WAIT completes.
  - Cleared when rom_download rises, and by RESET.
- **Reset generation:**
  - Counter reloads to RST_HOLD while RESET | user_reset | ~rom_loaded; otherwise it decrements to 0 and stops.
  - sys_reset = RESET | user_reset | ~rom_loaded | (cnt == 1), registered.
- **RESET mid-transfer:** FSM goes to IDLE, ioctl_wait drops, and each portN_req is set equal to its portN_ack, so no phantom transaction occurs. A byte in flight is abandoned.

## Timing
- Reset values:
  - port1_req = port1_ack, port2_req = port2_ack.
  - ioctl_wait 0, dl_wr 0, rom_loaded 0, sys_reset 1, cnt RST_HOLD.
  - Holding registers 0.
- Capture at cycle N. ioctl_wait is combinationally high at N and registered high from N+1.
- req toggles, or dl_wr pulses, at N+1. port*_a, _ds and _d are stable from N+1 until ack.
- Minimum byte period is 3 cycles for P1/P2 with zero-latency ack, and 2 cycles for BG.
- A second ioctl_wr edge while not in IDLE is a protocol violation. The HPS must honour ioctl_wait.
- sys_reset pulse: low RST_HOLD−1 cycles after the last reset cause clears, then high exactly 1 cycle, then low.
- A download with ioctl_index≠0 produces no req, dl_wr, wait or rom_loaded change.

## Test plan
- Write byte 0xA5 at addr 0x00003 with ack looped back 2 cycles late -> port1_req toggles once; port1_a=0x000001, ds=2'b10, d=0xA5A5; ioctl_wait high 4 cycles; port2_req unchanged.
- Write byte 0x3C at addr 0x1A001 -> s=0x8001; port2_a={2'b00, 15'h0001, 1'b0}, ds=2'b10, d=0x3C3C; port1_req unchanged.
- Write at 0x32010 -> dl_addr=0x10, dl_wr high exactly 1 cycle, no req toggles. Write at 0x3A000 -> nothing happens.
- Full download with ack held off 20 cycles on the last byte, then rom_download falls -> rom_loaded sets only after that ack. sys_reset deasserts, then re-pulses 1 cycle at cnt==1, RST_HOLD−1 cycles later.
- Assert RESET while in WAIT with ack pending -> next cycle: req==ack, ioctl_wait 0, rom_loaded 0, sys_reset 1.
- Download with ioctl_index=1 (mode byte) and index=254 (DIPs) -> no port, dl_wr or rom_loaded activity.
